rr_select_arbiter: RTL

RR_SELECT_ARBITER -- requirements
Module: rr_select_arbiter

---
 rtl/rr_select_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/rr_select_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time and a single shared
// data output that follows the din bit of the current grant holder.
module rr_select_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic       y,
    output logic       busy
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] hold_cnt, hold_cnt_nxt;
    logic [3:0] other_req;
    logic       rel;
    logic [3:0] gnt_nxt;
    logic       busy_nxt;

    // First set bit of r scanning start, start+1, ... with modulo-4 wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= 4'd0;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        other_req    = req & ~onehot(owner);
        // Hand-over when the owner lets go, or its hold budget is spent while someone waits.
        rel          = !req[owner] || ((hold_cnt == HOLD_LAST) && (|other_req));
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = OWN;
                    owner_nxt    = rr_pick(req, ptr);
                    hold_cnt_nxt = 4'd0;
                end
            end
            OWN: begin
                if (rel) begin
                    ptr_nxt = owner + 2'd1;
                    if (|other_req) begin
                        // The old owner is masked out so a same-cycle re-request cannot jump the queue.
                        owner_nxt    = rr_pick(other_req, owner + 2'd1);
                        hold_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == OWN);
        gnt_nxt  = busy_nxt ? onehot(owner_nxt) : 4'b0000;
        y        = |(gnt & din);
    end

endmodule
